// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: op and state encodings, byte-lane masks
// and the op classification helpers used by both the FSM and the load aligner.
package lsu_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LBU = 4'd1,
    LH  = 4'd2,
    LHU = 4'd3,
    LW  = 4'd4,
    LWL = 4'd5,
    LWR = 4'd6,
    SB  = 4'd8,
    SH  = 4'd9,
    SW  = 4'd10
  } lsu_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  localparam logic [3:0] LANES_ALL     = 4'b1111;
  localparam logic [3:0] LANES_LO_HALF = 4'b0011;
  localparam logic [3:0] LANES_HI_HALF = 4'b1100;
  localparam logic [3:0] LANE_0        = 4'b0001;

  function automatic logic is_load(input lsu_op_t op);
    return op inside {LB, LBU, LH, LHU, LW, LWL, LWR};
  endfunction

  function automatic logic is_store(input lsu_op_t op);
    return op inside {SB, SH, SW};
  endfunction

  // LWL/LWR are unaligned by design and never fault.
  function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] k);
    case (op)
      LH, LHU, SH: return k[0];
      LW, SW:      return k != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data formatter: picks the addressed lane(s) out of the bus
// word, extends them, and produces the register byte lanes to be written.
module lsu_load_align
  import lsu_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  k,
  input  logic [31:0] readdata,
  output logic [31:0] data,
  output logic [3:0]  byteenable
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    shifted    = readdata >> {k, 3'b000};
    byte_sel   = shifted[7:0];
    half_sel   = k[1] ? readdata[31:16] : readdata[15:0];
    data       = 32'h0;
    byteenable = LANES_ALL;
    case (op)
      LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LBU: data = {24'h0, byte_sel};
      LH:  data = {{16{half_sel[15]}}, half_sel};
      LHU: data = {16'h0, half_sel};
      LW:  data = readdata;
      // LWL fills the register from the top down, LWR from the bottom up.
      LWL: begin
        data       = readdata << {~k, 3'b000};
        byteenable = LANES_ALL << ~k;
      end
      LWR: begin
        data       = shifted;
        byteenable = LANES_ALL >> k;
      end
      default: byteenable = 4'b0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one Avalon-MM access at a time, load writeback to rt.
// Optional LSU_TIMEOUT_EN adds a waitrequest watchdog that ends the access as a bus fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] base,
  input  logic [15:0] offset,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic        addr_err,
  output logic        write_enable_ld,
  output logic [31:0] write_data_ld,
  output logic [3:0]  byteenable_ld,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  lsu_state_t  state_q, state_d;
  lsu_op_t     op_q, op_d;
  logic [1:0]  k_q, k_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        addr_err_q, addr_err_d;
  logic        we_ld_q, we_ld_d;
  logic [31:0] wdata_ld_q, wdata_ld_d;
  logic [3:0]  be_ld_q, be_ld_d;
  logic [31:0] avm_address_q, avm_address_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_write_q, avm_write_d;
  logic [31:0] avm_writedata_q, avm_writedata_d;
  logic [3:0]  avm_byteenable_q, avm_byteenable_d;

  lsu_op_t     op_in;
  logic [31:0] eff;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [31:0] ld_data;
  logic [3:0]  ld_be;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout;
  assign timeout = (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  assign op_in = lsu_op_t'(op);
  assign eff   = base + {{16{offset[15]}}, offset};

  // Store lanes and data are shaped from the request-time address and rt value.
  always_comb begin
    st_be   = LANES_ALL;
    st_data = 32'h0;
    case (op_in)
      SB: begin
        st_be   = LANE_0 << eff[1:0];
        st_data = {4{rt_data[7:0]}};
      end
      SH: begin
        st_be   = eff[1] ? LANES_HI_HALF : LANES_LO_HALF;
        st_data = {2{rt_data[15:0]}};
      end
      SW:      st_data = rt_data;
      default: st_data = 32'h0;
    endcase
  end

  lsu_load_align u_load_align (
    .op         (op_q),
    .k          (k_q),
    .readdata   (avm_readdata),
    .data       (ld_data),
    .byteenable (ld_be)
  );

  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    k_d              = k_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    addr_err_d       = 1'b0;
    we_ld_d          = 1'b0;
    wdata_ld_d       = wdata_ld_q;
    be_ld_d          = be_ld_q;
    avm_address_d    = avm_address_q;
    avm_read_d       = avm_read_q;
    avm_write_d      = avm_write_q;
    avm_writedata_d  = avm_writedata_q;
    avm_byteenable_d = avm_byteenable_q;
`ifdef LSU_TIMEOUT_EN
    stall_cnt_d      = stall_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op_in;
          k_d    = eff[1:0];
          busy_d = 1'b1;
          if (!is_load(op_in) && !is_store(op_in)) begin
            state_d = RESP;
            done_d  = 1'b1;
          end else if (is_misaligned(op_in, eff[1:0])) begin
            state_d    = RESP;
            done_d     = 1'b1;
            addr_err_d = 1'b1;
          end else begin
            state_d          = ACCESS;
            avm_address_d    = {eff[31:2], 2'b00};
            avm_read_d       = is_load(op_in);
            avm_write_d      = is_store(op_in);
            avm_byteenable_d = st_be;
            avm_writedata_d  = st_data;
`ifdef LSU_TIMEOUT_EN
            stall_cnt_d      = '0;
`endif
          end
        end
      end
      ACCESS: begin
        if (!avm_waitrequest) begin
          state_d     = RESP;
          done_d      = 1'b1;
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          if (is_load(op_q)) begin
            we_ld_d    = 1'b1;
            wdata_ld_d = ld_data;
            be_ld_d    = ld_be;
          end
        end
`ifdef LSU_TIMEOUT_EN
        else if (timeout) begin
          state_d     = RESP;
          done_d      = 1'b1;
          addr_err_d  = 1'b1;
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
        end else begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      op_q             <= LB;
      k_q              <= 2'b00;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      addr_err_q       <= 1'b0;
      we_ld_q          <= 1'b0;
      wdata_ld_q       <= 32'h0;
      be_ld_q          <= 4'h0;
      avm_address_q    <= 32'h0;
      avm_read_q       <= 1'b0;
      avm_write_q      <= 1'b0;
      avm_writedata_q  <= 32'h0;
      avm_byteenable_q <= 4'h0;
`ifdef LSU_TIMEOUT_EN
      stall_cnt_q      <= '0;
`endif
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      k_q              <= k_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      addr_err_q       <= addr_err_d;
      we_ld_q          <= we_ld_d;
      wdata_ld_q       <= wdata_ld_d;
      be_ld_q          <= be_ld_d;
      avm_address_q    <= avm_address_d;
      avm_read_q       <= avm_read_d;
      avm_write_q      <= avm_write_d;
      avm_writedata_q  <= avm_writedata_d;
      avm_byteenable_q <= avm_byteenable_d;
`ifdef LSU_TIMEOUT_EN
      stall_cnt_q      <= stall_cnt_d;
`endif
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign addr_err        = addr_err_q;
  assign write_enable_ld = we_ld_q;
  assign write_data_ld   = wdata_ld_q;
  assign byteenable_ld   = be_ld_q;
  assign avm_address     = avm_address_q;
  assign avm_read        = avm_read_q;
  assign avm_write       = avm_write_q;
  assign avm_writedata   = avm_writedata_q;
  assign avm_byteenable  = avm_byteenable_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, randomized
// transactions against a lane-level reference model, and multi-cycle corner cases.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int BUDGET = 300;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] base;
  logic [15:0] offset;
  logic [31:0] rt_data;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy, done, addr_err, write_enable_ld;
  logic [31:0] write_data_ld, avm_address, avm_writedata;
  logic [3:0]  byteenable_ld, avm_byteenable;
  logic        avm_read, avm_write;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .op              (op),
    .base            (base),
    .offset          (offset),
    .rt_data         (rt_data),
    .busy            (busy),
    .done            (done),
    .addr_err        (addr_err),
    .write_enable_ld (write_enable_ld),
    .write_data_ld   (write_data_ld),
    .byteenable_ld   (byteenable_ld),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] base;
    logic [15:0] off;
    logic [31:0] rt;
    logic [31:0] rd;
    int          w;
    int          e_lat;
    logic        e_err;
    logic        e_we;
    logic [31:0] e_data;
    logic [3:0]  e_be_ld;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [3:0]  e_avm_be;
    logic [31:0] e_wdata;
  } vec_t;

  typedef struct {
    int          lat;
    int          req;
    logic        rd, wr;
    logic [31:0] addr;
    logic [3:0]  avm_be;
    logic [31:0] wdata;
    logic        err, we;
    logic [31:0] data;
    logic [3:0]  be_ld;
    logic        unstable, busy_gap, clean_after;
  } obs_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t tv(input logic [3:0] o, input logic [31:0] b, input logic [15:0] of,
                              input logic [31:0] rt, input logic [31:0] rd, input int w,
                              input int lat, input logic err, input logic we,
                              input logic [31:0] data, input logic [3:0] be_ld,
                              input logic erd, input logic ewr, input logic [31:0] addr,
                              input logic [3:0] abe, input logic [31:0] wd);
    vec_t v;
    v.op = o; v.base = b; v.off = of; v.rt = rt; v.rd = rd; v.w = w;
    v.e_lat = lat; v.e_err = err; v.e_we = we; v.e_data = data; v.e_be_ld = be_ld;
    v.e_rd = erd; v.e_wr = ewr; v.e_addr = addr; v.e_avm_be = abe; v.e_wdata = wd;
    return v;
  endfunction

  // Reference model: works lane by lane on byte arrays, straight from the access rules.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    logic [31:0] eff;
    int          k, val;
    logic [7:0]  rb[4];
    logic [7:0]  sb[4];
    logic        ld, st, mis;
    r   = v;
    eff = v.base + {{16{v.off[15]}}, v.off};
    k   = int'(eff[1:0]);
    for (int j = 0; j < 4; j++) begin
      rb[j] = v.rd[8*j +: 8];
      sb[j] = v.rt[8*j +: 8];
    end
    r.e_err = 0; r.e_we = 0; r.e_data = 0; r.e_be_ld = 0; r.e_rd = 0; r.e_wr = 0;
    r.e_addr = eff & 32'hFFFF_FFFC; r.e_avm_be = 0; r.e_wdata = 0;
    ld  = v.op inside {LB, LBU, LH, LHU, LW, LWL, LWR};
    st  = v.op inside {SB, SH, SW};
    mis = ((v.op inside {LH, LHU, SH}) && (k % 2 != 0)) || ((v.op inside {LW, SW}) && k != 0);
    if (!ld && !st) begin
      r.e_lat = 1;
    end else if (mis) begin
      r.e_lat = 1;
      r.e_err = 1;
    end else begin
      r.e_lat = 2 + v.w;
      r.e_rd  = ld;
      r.e_wr  = st;
      if (ld) begin
        r.e_we = 1; r.e_avm_be = 4'hF; r.e_be_ld = 4'hF;
        case (v.op)
          LB, LBU: begin
            val = rb[k];
            if (v.op == LB && val >= 128) val -= 256;
            r.e_data = 32'(val);
          end
          LH, LHU: begin
            val = rb[k] + 256 * rb[k+1];
            if (v.op == LH && val >= 32768) val -= 65536;
            r.e_data = 32'(val);
          end
          LW: r.e_data = v.rd;
          LWL: begin
            r.e_be_ld = 4'h0;
            for (int j = 0; j <= k; j++) begin
              r.e_data[8*(3-k+j) +: 8] = rb[j];
              r.e_be_ld[3-k+j] = 1'b1;
            end
          end
          default: begin
            r.e_be_ld = 4'h0;
            for (int j = k; j < 4; j++) begin
              r.e_data[8*(j-k) +: 8] = rb[j];
              r.e_be_ld[j-k] = 1'b1;
            end
          end
        endcase
      end else begin
        for (int j = 0; j < 4; j++) begin
          if (v.op == SB) begin
            r.e_wdata[8*j +: 8] = sb[0];
            r.e_avm_be[j] = (j == k);
          end else if (v.op == SH) begin
            r.e_wdata[8*j +: 8] = sb[j % 2];
            r.e_avm_be[j] = (j == k) || (j == k + 1);
          end else begin
            r.e_wdata[8*j +: 8] = sb[j];
            r.e_avm_be[j] = 1'b1;
          end
        end
      end
    end
    return r;
  endfunction

  // Issues one request from an idle DUT and acts as the Avalon slave,
  // holding waitrequest high for the first t_w request cycles.
  task automatic run_op(input vec_t v, output obs_t o);
    int stalls_left;
    stalls_left = v.w;
    o.lat = -1; o.req = 0; o.rd = 0; o.wr = 0; o.addr = 0; o.avm_be = 0; o.wdata = 0;
    o.err = 0; o.we = 0; o.data = 0; o.be_ld = 0;
    o.unstable = 0; o.busy_gap = 0; o.clean_after = 0;
    op = v.op; base = v.base; offset = v.off; rt_data = v.rt;
    avm_readdata = v.rd; avm_waitrequest = 1'b0; start = 1'b1;
    for (int c = 1; c <= BUDGET && o.lat < 0; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (!busy) o.busy_gap = 1;
      if (avm_read || avm_write) begin
        if (o.req == 0) begin
          o.rd = avm_read; o.wr = avm_write; o.addr = avm_address;
          o.avm_be = avm_byteenable; o.wdata = avm_writedata;
        end else if (avm_read !== o.rd || avm_write !== o.wr || avm_address !== o.addr ||
                     avm_byteenable !== o.avm_be || avm_writedata !== o.wdata) begin
          o.unstable = 1;
        end
        o.req++;
        avm_waitrequest = (stalls_left > 0);
        if (stalls_left > 0) stalls_left--;
      end else begin
        avm_waitrequest = 1'b0;
      end
      o.we = o.we | write_enable_ld;
      if (done) begin
        o.lat = c; o.err = addr_err; o.data = write_data_ld; o.be_ld = byteenable_ld;
      end
    end
    @(posedge clk); #1;
    avm_waitrequest = 1'b0;
    o.clean_after = !done && !busy && !write_enable_ld && !avm_read && !avm_write;
  endtask

  task automatic verify(input string tag, input vec_t v, input obs_t o);
    int e_req;
    e_req = (v.e_rd || v.e_wr) ? v.e_lat - 1 : 0;
    check({tag, " done_latency"}, o.lat, v.e_lat);
    check({tag, " addr_err"}, o.err, v.e_err);
    check({tag, " write_enable_ld"}, o.we, v.e_we);
    check({tag, " request_cycles"}, o.req, e_req);
    check({tag, " busy_gap"}, o.busy_gap, 1'b0);
    check({tag, " idle_after_done"}, o.clean_after, 1'b1);
    if (v.e_we) begin
      check({tag, " write_data_ld"}, o.data, v.e_data);
      check({tag, " byteenable_ld"}, o.be_ld, v.e_be_ld);
    end
    if (e_req > 0) begin
      check({tag, " avm_address"}, o.addr, v.e_addr);
      check({tag, " avm_read"}, o.rd, v.e_rd);
      check({tag, " avm_write"}, o.wr, v.e_wr);
      check({tag, " avm_byteenable"}, o.avm_be, v.e_avm_be);
      check({tag, " request_stable"}, o.unstable, 1'b0);
      if (v.e_wr) check({tag, " avm_writedata"}, o.wdata, v.e_wdata);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    obs_t o;
    int   dones, done_at;
    logic saw_write;
    logic [31:0] seen_addr, seen_data;

    rst = 1'b1; start = 1'b0; op = 4'h0; base = 32'h0; offset = 16'h0; rt_data = 32'h0;
    avm_readdata = 32'h0; avm_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset addr_err", addr_err, 0);
    check("reset write_enable_ld", write_enable_ld, 0);
    check("reset write_data_ld", write_data_ld, 0);
    check("reset byteenable_ld", byteenable_ld, 0);
    check("reset avm_address", avm_address, 0);
    check("reset avm_read", avm_read, 0);
    check("reset avm_write", avm_write, 0);
    check("reset avm_writedata", avm_writedata, 0);
    check("reset avm_byteenable", avm_byteenable, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    //        op     base          off       rt            rd            w  lat err we data          be_ld rd wr addr          abe   wdata
    vecs.push_back(tv(LW,  32'h1000,     16'h0004, 32'h0,        32'hDEADBEEF, 2, 4, 0, 1, 32'hDEADBEEF, 4'hF, 1, 0, 32'h1004,     4'hF, 32'h0));
    vecs.push_back(tv(LB,  32'h2000,     16'h0003, 32'h0,        32'h80FF1234, 0, 2, 0, 1, 32'hFFFFFF80, 4'hF, 1, 0, 32'h2000,     4'hF, 32'h0));
    vecs.push_back(tv(LBU, 32'h2000,     16'h0003, 32'h0,        32'h80FF1234, 0, 2, 0, 1, 32'h00000080, 4'hF, 1, 0, 32'h2000,     4'hF, 32'h0));
    vecs.push_back(tv(LB,  32'h2000,     16'h0001, 32'h0,        32'h80FF1234, 0, 2, 0, 1, 32'h00000012, 4'hF, 1, 0, 32'h2000,     4'hF, 32'h0));
    vecs.push_back(tv(SH,  32'h3000,     16'h0002, 32'h0000ABCD, 32'h0,        1, 3, 0, 0, 32'h0,        4'h0, 0, 1, 32'h3000,     4'hC, 32'hABCDABCD));
    vecs.push_back(tv(LWL, 32'h4000,     16'h0001, 32'h0,        32'h44332211, 0, 2, 0, 1, 32'h22110000, 4'hC, 1, 0, 32'h4000,     4'hF, 32'h0));
    vecs.push_back(tv(LWR, 32'h4000,     16'h0001, 32'h0,        32'h44332211, 0, 2, 0, 1, 32'h00443322, 4'h7, 1, 0, 32'h4000,     4'hF, 32'h0));
    vecs.push_back(tv(LWL, 32'h4000,     16'h0000, 32'h0,        32'h44332211, 0, 2, 0, 1, 32'h11000000, 4'h8, 1, 0, 32'h4000,     4'hF, 32'h0));
    vecs.push_back(tv(LWR, 32'h4000,     16'h0003, 32'h0,        32'h44332211, 0, 2, 0, 1, 32'h00000044, 4'h1, 1, 0, 32'h4000,     4'hF, 32'h0));
    vecs.push_back(tv(LH,  32'h5000,     16'h0001, 32'h0,        32'h12345678, 0, 1, 1, 0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 32'h0));
    vecs.push_back(tv(SW,  32'h5000,     16'h0004, 32'h12345678, 32'h0,        0, 2, 0, 0, 32'h0,        4'h0, 0, 1, 32'h5004,     4'hF, 32'h12345678));
    vecs.push_back(tv(LHU, 32'h6004,     16'hFFFE, 32'h0,        32'h80017F00, 0, 2, 0, 1, 32'h00008001, 4'hF, 1, 0, 32'h6000,     4'hF, 32'h0));
    vecs.push_back(tv(LH,  32'h6004,     16'hFFFE, 32'h0,        32'h80017F00, 0, 2, 0, 1, 32'hFFFF8001, 4'hF, 1, 0, 32'h6000,     4'hF, 32'h0));
    vecs.push_back(tv(SB,  32'h7000,     16'h0002, 32'h123456A5, 32'h0,        0, 2, 0, 0, 32'h0,        4'h0, 0, 1, 32'h7000,     4'h4, 32'hA5A5A5A5));
    vecs.push_back(tv(4'd7,32'h7100,     16'h0000, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 32'h0));
    vecs.push_back(tv(LW,  32'h8000,     16'h0002, 32'h0,        32'h0,        0, 1, 1, 0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 32'h0));
    vecs.push_back(tv(SW,  32'h8000,     16'h0001, 32'h0,        32'h0,        0, 1, 1, 0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 32'h0));
    vecs.push_back(tv(LW,  32'hFFFFFFFC, 16'h0008, 32'h0,        32'hCAFEF00D, 1, 3, 0, 1, 32'hCAFEF00D, 4'hF, 1, 0, 32'h00000004, 4'hF, 32'h0));
`ifdef LSU_TIMEOUT_EN
    vecs.push_back(tv(LW,  32'h9000,     16'h0000, 32'h0,        32'h0,        100, 5, 1, 0, 32'h0,      4'h0, 1, 0, 32'h9000,     4'hF, 32'h0));
`else
    vecs.push_back(tv(LW,  32'h9000,     16'h0000, 32'h0,        32'h600DF00D, 200, 202, 0, 1, 32'h600DF00D, 4'hF, 1, 0, 32'h9000, 4'hF, 32'h0));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i], o);
      verify($sformatf("vec%0d", i), vecs[i], o);
    end

    for (int i = 0; i < 80; i++) begin
      v.op   = 4'($urandom_range(0, 15));
      v.base = $urandom;
      v.off  = 16'($urandom);
      v.rt   = $urandom;
      v.rd   = $urandom;
      v.w    = $urandom_range(0, 3);
      v = model(v);
      run_op(v, o);
      verify($sformatf("rand%0d op%0d", i, v.op), v, o);
    end

    // start pulses while busy must be dropped, not queued
    op = LW; base = 32'hA000; offset = 16'h0; rt_data = 32'h0;
    avm_readdata = 32'h0BADF00D; avm_waitrequest = 1'b0; start = 1'b1;
    dones = 0; done_at = -1; saw_write = 1'b0; seen_addr = 32'h0; seen_data = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      start = (c <= 2);
      op = SW; base = 32'hB000; rt_data = 32'h55AA55AA;
      avm_waitrequest = (c <= 3);
      if (c == 1) seen_addr = avm_address;
      if (avm_write) saw_write = 1'b1;
      if (done) begin
        dones++;
        done_at = c;
        seen_data = write_data_ld;
      end
    end
    start = 1'b0;
    check("busy_start done_count", dones, 1);
    check("busy_start done_cycle", done_at, 5);
    check("busy_start no_write", saw_write, 1'b0);
    check("busy_start avm_address", seen_addr, 32'hA000);
    check("busy_start load_data", seen_data, 32'h0BADF00D);

    // synchronous reset in the middle of a stalled load
    op = LW; base = 32'hC000; offset = 16'h0; avm_waitrequest = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; avm_waitrequest = 1'b1;
    check("mid_rst read_before", avm_read, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst avm_read", avm_read, 1'b0);
    check("mid_rst busy", busy, 1'b0);
    check("mid_rst write_enable_ld", write_enable_ld, 1'b0);
    check("mid_rst done", done, 1'b0);
    avm_waitrequest = 1'b0;
    dones = 0; saw_write = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done || write_enable_ld || avm_read || busy) dones++;
    end
    check("mid_rst quiet_after", dones, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
